// File: rtl/cmos_gate_bist_pkg.sv
// cmos_gate_bist_pkg: shared FSM encodings, limits and helpers for the CMOS gate BIST block.
package cmos_gate_bist_pkg;

  localparam int N_IN_MAX  = 4;
  localparam int LANES_MAX = 16;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_APPLY  = 3'd1,
    S_SAMPLE = 3'd2,
    S_CHECK  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  function automatic logic [4:0] popcount16(input logic [LANES_MAX-1:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < LANES_MAX; i++) c = c + 5'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/cmos_gate_bist_if.sv
// cmos_gate_bist_if: functional and self-test signal bundle of the CMOS gate bank.
interface cmos_gate_bist_if #(
  parameter int N_IN  = 2,
  parameter int LANES = 4
);
  localparam int CW = N_IN + $clog2(LANES) + 1;

  logic                  op_nand;
  logic [LANES*N_IN-1:0] lane_a;
  logic [LANES-1:0]      flt_inv;
  logic                  start;
  logic [LANES-1:0]      lane_y;
  logic                  busy;
  logic                  done;
  logic                  pass;
  logic [CW-1:0]         err_cnt;

  modport master (
    output op_nand, lane_a, flt_inv, start,
    input  lane_y, busy, done, pass, err_cnt
  );

  modport slave (
    input  op_nand, lane_a, flt_inv, start,
    output lane_y, busy, done, pass, err_cnt
  );

endinterface

// File: rtl/cmos_gate_bist_gate.sv
// cmos_gate_n: N_IN-input switch-level NOR/NAND; both networks exist, nand_sel steers the output.
module cmos_gate_n #(
  parameter int N_IN = 2
) (
  input  logic [N_IN-1:0] a,
  input  logic            nand_sel,
  output wire             y
);
  supply1 vdd;
  supply0 gnd;
  wire y_nor;
  wire y_nand;

  // Parallel halves: NOR pull-down and NAND pull-up, one device per input.
  for (genvar i = 0; i < N_IN; i++) begin : g_par
    nmos (y_nor, gnd, a[i]);
    pmos (y_nand, vdd, a[i]);
  end

  // Series halves use discrete scalar nodes so each link of the chain is its own net.
  if (N_IN == 2) begin : g_s2
    wire p1, n1;
    pmos (p1, vdd, a[0]);
    pmos (y_nor, p1, a[1]);
    nmos (n1, gnd, a[0]);
    nmos (y_nand, n1, a[1]);
  end else if (N_IN == 3) begin : g_s3
    wire p1, p2, n1, n2;
    pmos (p1, vdd, a[0]);
    pmos (p2, p1, a[1]);
    pmos (y_nor, p2, a[2]);
    nmos (n1, gnd, a[0]);
    nmos (n2, n1, a[1]);
    nmos (y_nand, n2, a[2]);
  end else begin : g_s4
    wire p1, p2, p3, n1, n2, n3;
    pmos (p1, vdd, a[0]);
    pmos (p2, p1, a[1]);
    pmos (p3, p2, a[2]);
    pmos (y_nor, p3, a[3]);
    nmos (n1, gnd, a[0]);
    nmos (n2, n1, a[1]);
    nmos (n3, n2, a[2]);
    nmos (y_nand, n3, a[3]);
  end

  nmos (y, y_nand, nand_sel);
  pmos (y, y_nor, nand_sel);

endmodule

// File: rtl/cmos_gate_bist.sv
// cmos_gate_bist: bank of LANES switch-level CMOS gates with registered outputs and an exhaustive-vector self-test.
module cmos_gate_bist
  import cmos_gate_bist_pkg::*;
#(
  parameter int N_IN  = 2,
  parameter int LANES = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  cmos_gate_bist_if.slave bus
);
  localparam int CW = N_IN + $clog2(LANES) + 1;
  localparam logic [N_IN:0] VLAST = (N_IN + 1)'((1 << N_IN) - 1);

  state_t                st;
  logic [N_IN:0]         vec;
  logic                  mode;
  logic [LANES-1:0]      smp;
  logic                  idle;
  logic [LANES*N_IN-1:0] gin;
  logic                  sel;
  wire  [LANES-1:0]      gy;
  logic                  expv;
  logic [LANES-1:0]      mism;
  logic [4:0]            pop;
  logic [CW:0]           sum;
  logic [CW-1:0]         err_nxt;

  // Unknown or floating samples never match, so they are counted as failures.
  always_comb begin
    idle    = st == S_IDLE;
    gin     = idle ? bus.lane_a : {LANES{vec[N_IN-1:0]}};
    sel     = idle ? bus.op_nand : mode;
    expv    = mode ? ~&vec[N_IN-1:0] : ~|vec[N_IN-1:0];
    mism    = '0;
    for (int k = 0; k < LANES; k++) mism[k] = !(smp[k] === expv);
    pop     = popcount16(LANES_MAX'(mism));
    sum     = (CW + 1)'(bus.err_cnt) + (CW + 1)'(pop);
    err_nxt = sum[CW] ? '1 : sum[CW-1:0];
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    cmos_gate_n #(.N_IN(N_IN)) u_gate (
      .a        (gin[k*N_IN +: N_IN]),
      .nand_sel (sel),
      .y        (gy[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st          <= S_IDLE;
      vec         <= '0;
      mode        <= 1'b0;
      smp         <= '0;
      bus.lane_y  <= '0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.pass    <= 1'b0;
      bus.err_cnt <= '0;
    end else begin
      case (st)
        S_IDLE: begin
          bus.lane_y <= gy;
          if (bus.start) begin
            mode        <= bus.op_nand;
            bus.err_cnt <= '0;
            bus.pass    <= 1'b0;
            vec         <= '0;
            bus.busy    <= 1'b1;
            st          <= S_APPLY;
          end
        end
        S_APPLY: st <= S_SAMPLE;
        S_SAMPLE: begin
          smp <= gy ^ bus.flt_inv;
          st  <= S_CHECK;
        end
        S_CHECK: begin
          bus.err_cnt <= err_nxt;
          if (vec == VLAST) begin
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            bus.pass <= err_nxt == '0;
            st       <= S_DONE;
          end else begin
            vec <= vec + (N_IN + 1)'(1);
            st  <= S_APPLY;
          end
        end
        S_DONE: begin
          bus.done <= 1'b0;
          st       <= S_IDLE;
        end
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule
